// File: rtl/rr_req_queue.sv
// Request front-end for a 2-client round-robin arbiter: saturating pending
// counts per client, with in-flight token tracking so each request is acked once.
module rr_req_queue #(
  parameter int CNT_W = 4,
  parameter int LAT   = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push0,
  input  logic             push1,
  input  logic             ack0,
  input  logic             ack1,
  output logic             ir0,
  output logic             ir1,
  output logic [CNT_W-1:0] pend0,
  output logic [CNT_W-1:0] pend1,
  output logic             full0,
  output logic             full1,
  output logic             ovf,
  output logic             spur
);

  // Handshake: ir_i raised in cycle n is answered in cycle n+LAT, when the
  // token it launched reaches the head; ack_i high then is a grant, low is a
  // denial. An ack with no head token is spurious and ignored.

  localparam int PW = CNT_W + $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] PMAX = '1;

  logic [CNT_W-1:0] pend [2];
  logic [LAT-1:0]   tok  [2];
  logic [1:0]       push_v, ack_v, ir_v, full_v, ret_v, acc_v, drop_v, bad_v;

  function automatic logic [PW-1:0] popcnt(input logic [LAT-1:0] t);
    logic [PW-1:0] c;
    c = '0;
    for (int k = 0; k < LAT; k++) c = c + PW'(t[k]);
    return c;
  endfunction

  assign push_v = {push1, push0};
  assign ack_v  = {ack1, ack0};

  always_comb begin
    ir_v   = '0;
    full_v = '0;
    ret_v  = '0;
    acc_v  = '0;
    drop_v = '0;
    bad_v  = '0;
    for (int i = 0; i < 2; i++) begin
      // Request only for pending entries not already covered by a token.
      ir_v[i]   = {{(PW-CNT_W){1'b0}}, pend[i]} > popcnt(tok[i]);
      full_v[i] = (pend[i] == PMAX);
      ret_v[i]  = tok[i][LAT-1] & ack_v[i];
      acc_v[i]  = push_v[i] & (~full_v[i] | ret_v[i]);
      drop_v[i] = push_v[i] & full_v[i] & ~ret_v[i];
      bad_v[i]  = ack_v[i] & ~tok[i][LAT-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        pend[i] <= '0;
        tok[i]  <= '0;
      end
      ovf  <= 1'b0;
      spur <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (acc_v[i] && !ret_v[i])      pend[i] <= pend[i] + 1'b1;
        else if (ret_v[i] && !acc_v[i]) pend[i] <= pend[i] - 1'b1;
        tok[i] <= LAT'({tok[i], ir_v[i]});
      end
      ovf  <= ovf  | (|drop_v);
      spur <= spur | (|bad_v);
    end
  end

  assign ir0   = ir_v[0];
  assign ir1   = ir_v[1];
  assign pend0 = pend[0];
  assign pend1 = pend[1];
  assign full0 = full_v[0];
  assign full1 = full_v[1];

endmodule

// File: tb/tb_rr_req_queue.sv
// Bench for rr_req_queue: behavioural arbiter responder, queue-of-issue-times
// reference model checked every cycle, plus directed literal checks.
module tb_rr_req_queue;

  localparam int CNT_W = 4;
  localparam int LAT   = 2;
  localparam int PMAX  = 15;

  logic             clock;
  logic             reset_n;
  logic             push0, push1;
  logic             ack0, ack1;
  logic             ir0, ir1;
  logic [CNT_W-1:0] pend0, pend1;
  logic             full0, full1;
  logic             ovf, spur;

  rr_req_queue #(.CNT_W(CNT_W), .LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .push0(push0), .push1(push1),
    .ack0(ack0), .ack1(ack1),
    .ir0(ir0), .ir1(ir1),
    .pend0(pend0), .pend1(pend1),
    .full0(full0), .full1(full1),
    .ovf(ovf), .spur(spur)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // behavioural arbiter: answers ir LAT cycles later, alternates on conflict
  logic           en0, en1, deny0, deny0_done, inj1;
  logic           arb0, arb1, last;
  logic [LAT-1:0] hist0, hist1;
  initial begin
    arb0 = 0; arb1 = 0; last = 0; hist0 = '0; hist1 = '0; deny0_done = 0;
  end
  always @(negedge clock) begin
    logic g0, g1;
    g0 = hist0[LAT-1] & en0;
    g1 = hist1[LAT-1] & en1;
    if (g0 && deny0 && !deny0_done) begin
      g0 = 0;
      deny0_done = 1;
    end
    if (g0 && g1) begin
      if (last == 1'b0) g0 = 0;
      else g1 = 0;
    end
    if (g0) last = 0;
    if (g1) last = 1;
    arb0 = g0;
    arb1 = g1;
    hist0 = LAT'({hist0, ir0});
    hist1 = LAT'({hist1, ir1});
  end
  assign ack0 = arb0;
  assign ack1 = arb1 | inj1;

  int ack0_n = 0, ack1_n = 0, ir0_hi = 0;
  always @(posedge clock) if (reset_n) begin
    if (arb0) ack0_n++;
    if (arb1) ack1_n++;
  end
  always @(posedge clock) begin
    #1;
    if (ir0) ir0_hi++;
  end

  // reference model: pending counts and lists of issue cycles still in flight
  int m_pend [2];
  int m_it   [2][LAT+1];
  int m_nt   [2];
  bit m_ovf, m_spur;
  int cyc = 0;
  initial begin
    m_pend[0] = 0; m_pend[1] = 0; m_nt[0] = 0; m_nt[1] = 0; m_ovf = 0; m_spur = 0;
  end

  always @(negedge reset_n) begin
    m_pend[0] = 0; m_pend[1] = 0; m_nt[0] = 0; m_nt[1] = 0; m_ovf = 0; m_spur = 0;
  end

  always @(posedge clock) begin
    bit p, a, req, head, full, ret;
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        p    = (i == 0) ? push0 : push1;
        a    = (i == 0) ? ack0 : ack1;
        req  = m_pend[i] > m_nt[i];
        head = (m_nt[i] > 0) && (m_it[i][0] == cyc - LAT);
        full = (m_pend[i] == PMAX);
        ret  = head && a;
        if (a && !head) m_spur = 1;
        if (p && full && !ret) m_ovf = 1;
        else if (p && !ret)    m_pend[i]++;
        else if (!p && ret)    m_pend[i]--;
        if (head) begin
          for (int k = 0; k < LAT; k++) m_it[i][k] = m_it[i][k+1];
          m_nt[i]--;
        end
        if (req) begin
          m_it[i][m_nt[i]] = cyc;
          m_nt[i]++;
        end
      end
    end
    cyc++;
  end

  // scoreboard compare, every cycle out of reset
  always @(negedge clock) if (reset_n) begin
    chk("m_ir0",   int'(ir0),   int'(m_pend[0] > m_nt[0]));
    chk("m_ir1",   int'(ir1),   int'(m_pend[1] > m_nt[1]));
    chk("m_pend0", int'(pend0), m_pend[0]);
    chk("m_pend1", int'(pend1), m_pend[1]);
    chk("m_full0", int'(full0), int'(m_pend[0] == PMAX));
    chk("m_full1", int'(full1), int'(m_pend[1] == PMAX));
    chk("m_ovf",   int'(ovf),   int'(m_ovf));
    chk("m_spur",  int'(spur),  int'(m_spur));
  end

  // driver tasks
  task automatic step(input logic p0, input logic p1);
    @(negedge clock); #1;
    push0 = p0;
    push1 = p1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  int a0, a1, h;

  initial begin
    reset_n = 0; push0 = 0; push1 = 0; inj1 = 0;
    en0 = 1; en1 = 1; deny0 = 0;
    wait_cyc(2);
    chk("rst_pend0", int'(pend0), 0);
    chk("rst_ir1",   int'(ir1),   0);
    chk("rst_full0", int'(full0), 0);
    chk("rst_ovf",   int'(ovf),   0);
    reset_n = 1;

    // single request
    a0 = ack0_n; h = ir0_hi;
    step(1, 0); step(0, 0); wait_cyc(8);
    chk("single_ir0_cycles", ir0_hi - h, 1);
    chk("single_acks", ack0_n - a0, 1);
    chk("single_pend0", int'(pend0), 0);
    chk("single_spur", int'(spur), 0);

    // first ack withheld
    deny0 = 1;
    a0 = ack0_n; h = ir0_hi;
    step(1, 0); step(0, 0); wait_cyc(10);
    chk("deny_ir0_cycles", ir0_hi - h, 2);
    chk("deny_acks", ack0_n - a0, 1);
    chk("deny_pend0", int'(pend0), 0);

    // streaming both clients
    a0 = ack0_n; a1 = ack1_n;
    repeat (3) step(1, 1);
    step(0, 0); wait_cyc(30);
    chk("stream_acks0", ack0_n - a0, 3);
    chk("stream_acks1", ack1_n - a1, 3);
    chk("stream_pend0", int'(pend0), 0);
    chk("stream_pend1", int'(pend1), 0);
    chk("stream_ovf", int'(ovf), 0);
    chk("stream_spur", int'(spur), 0);

    // saturation of client 1
    en1 = 0;
    repeat (15) step(0, 1);
    @(negedge clock); #1;
    push1 = 0; en1 = 1;
    chk("sat_pend1", int'(pend1), 15);
    chk("sat_full1", int'(full1), 1);
    repeat (3) step(0, 1);
    @(negedge clock); #1;
    push1 = 1; en1 = 0;
    step(0, 0); wait_cyc(2);
    chk("coinc_pend1", int'(pend1), 15);
    chk("coinc_ovf", int'(ovf), 0);
    step(0, 1); step(0, 0); wait_cyc(2);
    chk("ovf_pend1", int'(pend1), 15);
    chk("ovf_set", int'(ovf), 1);

    // drain, then spurious ack
    en1 = 1;
    wait_cyc(25);
    chk("drain_pend1", int'(pend1), 0);
    @(negedge clock); #1; inj1 = 1;
    @(negedge clock); #1; inj1 = 0;
    wait_cyc(2);
    chk("spur_set", int'(spur), 1);
    chk("spur_pend1", int'(pend1), 0);

    // async reset between edges
    repeat (3) step(1, 0);
    chk("pre_reset_pend0_nz", int'(pend0 != 0), 1);
    @(negedge clock); #2;
    reset_n = 0;
    #1;
    chk("arst_pend0", int'(pend0), 0);
    chk("arst_pend1", int'(pend1), 0);
    chk("arst_ir0",   int'(ir0),   0);
    chk("arst_ir1",   int'(ir1),   0);
    chk("arst_ovf",   int'(ovf),   0);
    chk("arst_spur",  int'(spur),  0);
    push0 = 0;
    wait_cyc(3);
    reset_n = 1;
    a0 = ack0_n; h = ir0_hi;
    step(1, 0); step(0, 0); wait_cyc(8);
    chk("post_rst_ir0_cycles", ir0_hi - h, 1);
    chk("post_rst_acks", ack0_n - a0, 1);
    chk("post_rst_pend0", int'(pend0), 0);
    chk("post_rst_spur", int'(spur), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
